// File: rtl/serial_add_pkg.sv
// Shared types and sizing helpers for the bit-serial adder controller.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit counter width: clog2(width), never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Single-bit full adder: the only arithmetic cell the serial controller uses.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ cin;
    assign co = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full_adder_cell sequenced LSB-first over WIDTH bits.
// Optional subtract mode and signed-overflow flag are built with SERIAL_ADD_SUB_EN.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
    output logic             ovf,
`endif
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int               CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr, sum_q, sum_shift, b_load;
    logic [CNT_W-1:0] cnt;
    logic             carry, carry_load, cout_q;
    logic             fa_s, fa_co, last;

    full_adder_cell u_fa (
        .a   (a_sr[0]),
        .b   (b_sr[0]),
        .cin (carry),
        .s   (fa_s),
        .co  (fa_co)
    );

`ifdef SERIAL_ADD_SUB_EN
    logic a_msb, b_msb, ovf_q;

    // Subtraction is A + ~B + 1, so the carry flop seeds with 1 and cin is ignored.
    assign b_load     = sub ? ~b : b;
    assign carry_load = sub ? 1'b1 : cin;
    assign ovf        = ovf_q;
`else
    assign b_load     = b;
    assign carry_load = cin;
`endif

    assign last = (cnt == LAST);

    always_comb begin
        sum_shift            = sum_q >> 1;
        sum_shift[WIDTH-1]   = fa_s;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Operand shifters, carry, counter and result; counter stops at LAST so it never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_q  <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
            cnt    <= '0;
`ifdef SERIAL_ADD_SUB_EN
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            ovf_q  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b_load;
                        carry <= carry_load;
                        cnt   <= '0;
`ifdef SERIAL_ADD_SUB_EN
                        a_msb <= a[WIDTH-1];
                        b_msb <= b_load[WIDTH-1];
`endif
                    end
                end
                RUN: begin
                    sum_q <= sum_shift;
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    carry <= fa_co;
                    if (last) begin
                        cout_q <= fa_co;
`ifdef SERIAL_ADD_SUB_EN
                        ovf_q  <= (a_msb == b_msb) && (fa_s != a_msb);
`endif
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready = (state == IDLE);
    assign busy  = (state == RUN);
    assign done  = (state == DONE);
    assign sum   = sum_q;
    assign cout  = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl with a result scoreboard (WIDTH=8 and WIDTH=1 instances).
module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start8 = 1'b0, cin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0, sum8;
    logic       ready8, busy8, done8, cout8;

    logic       start1 = 1'b0, cin1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0, sum1;
    logic       ready1, busy1, done1, cout1;

`ifdef SERIAL_ADD_SUB_EN
    logic       sub8 = 1'b0, ovf8;
    logic       sub1 = 1'b0, ovf1;
`endif

    int checks = 0;
    int errors = 0;

    // Scoreboard entries: {ovf, cout, sum}.
    logic [9:0] sb8[$];
    logic [1:0] sb1[$];

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
`ifdef SERIAL_ADD_SUB_EN
        .sub(sub8), .ovf(ovf8),
`endif
        .ready(ready8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
`ifdef SERIAL_ADD_SUB_EN
        .sub(sub1), .ovf(ovf1),
`endif
        .ready(ready1), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One WIDTH=8 operation; poke>0 pulses start during that RUN cycle, rstc>0 resets there.
    task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic ci,
                       input logic sb_sub, input int poke, input int rstc);
        logic [7:0] be;
        logic       ce;
        logic [8:0] e;
        logic       eovf;
        logic [9:0] ent;
        int         lat;
        int         pulses;
        be   = sb_sub ? ~bv : bv;
        ce   = sb_sub ? 1'b1 : ci;
        e    = {1'b0, av} + {1'b0, be} + {8'b0, ce};
        eovf = (av[7] == be[7]) && (e[7] != av[7]);
        a8 = av; b8 = bv; cin8 = ci; start8 = 1'b1;
`ifdef SERIAL_ADD_SUB_EN
        sub8 = sb_sub;
`endif
        if (rstc == 0) sb8.push_back({eovf, e});
        lat = 0;
        pulses = 0;
        @(posedge clk);
        #1 start8 = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk);
            #1;
            start8 = (n == poke);
            if (n == poke) begin
                a8 = 8'h11;
                b8 = 8'h11;
            end
            if (n == rstc) begin
                rst = 1'b1;
                #1;
                check("abort_sum",   64'(sum8),   64'h0);
                check("abort_cout",  64'(cout8),  64'h0);
                check("abort_busy",  64'(busy8),  64'h0);
                check("abort_done",  64'(done8),  64'h0);
                check("abort_ready", 64'(ready8), 64'h1);
                rst = 1'b0;
                return;
            end
            @(negedge clk);
            if (done8) begin
                pulses++;
                if (lat == 0) begin
                    lat = n;
                    if (sb8.size() == 0) begin
                        check("sb8_empty", 64'(sb8.size()), 64'h1);
                    end else begin
                        ent = sb8.pop_front();
                        check("sum8",  64'(sum8),  64'(ent[7:0]));
                        check("cout8", 64'(cout8), 64'(ent[8]));
`ifdef SERIAL_ADD_SUB_EN
                        check("ovf8",  64'(ovf8),  64'(ent[9]));
`endif
                    end
                end
            end
            if (lat != 0 && n == lat + 1) begin
                check("ready_after_done", 64'(ready8), 64'h1);
                check("done_one_cycle",   64'(done8),  64'h0);
            end
        end
        check("latency8",    64'(lat),    64'd8);
        check("done_pulses", 64'(pulses), 64'd1);
        check("sum8_hold",   64'(sum8),   64'(e[7:0]));
    endtask

    initial begin
        int prev;
        int ndone;
        logic [1:0] ent1;

        // Reset state
        #2;
        check("rst_ready", 64'(ready8), 64'h1);
        check("rst_busy",  64'(busy8),  64'h0);
        check("rst_done",  64'(done8),  64'h0);
        check("rst_sum",   64'(sum8),   64'h0);
        check("rst_cout",  64'(cout8),  64'h0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        op8(8'h5A, 8'h3C, 1'b0, 1'b0, 0, 0);
        op8(8'hFF, 8'h01, 1'b0, 1'b0, 0, 0);
        op8(8'hFF, 8'hFF, 1'b1, 1'b0, 0, 0);
        op8(8'h5A, 8'h3C, 1'b0, 1'b0, 3, 0);
        op8(8'h5A, 8'h3C, 1'b0, 1'b0, 0, 4);
        op8(8'h01, 8'h02, 1'b0, 1'b0, 0, 0);
`ifdef SERIAL_ADD_SUB_EN
        op8(8'h10, 8'h20, 1'b0, 1'b1, 0, 0);
        op8(8'h80, 8'h01, 1'b0, 1'b1, 0, 0);
        sub8 = 1'b0;
`endif
        check("sb8_drained", 64'(sb8.size()), 64'd0);

        // WIDTH=1 with start held high: one operation every 3 cycles
        @(negedge clk);
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; start1 = 1'b1;
        prev = -1;
        ndone = 0;
        for (int n = 0; n < 12; n++) begin
            if (ready1 && start1) sb1.push_back(2'b11);
            @(posedge clk);
            @(negedge clk);
            if (done1) begin
                ndone++;
                if (sb1.size() == 0) begin
                    check("sb1_empty", 64'(sb1.size()), 64'h1);
                end else begin
                    ent1 = sb1.pop_front();
                    check("sum1",  64'(sum1),  64'(ent1[0]));
                    check("cout1", 64'(cout1), 64'(ent1[1]));
                end
                if (prev >= 0) check("done1_period", 64'(n - prev), 64'd3);
                prev = n;
            end
        end
        start1 = 1'b0;
        check("done1_count", 64'(ndone), 64'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial adder controller: accepts two WIDTH-bit operands and a carry-in, then sequences a single 1-bit full-adder cell over them LSB-first, one bit per clock. It owns the operand shift registers, the carry flip-flop, the result register and a start/busy/done handshake. It is the sequencing layer above the 1-bit full-adder datapath and trades throughput for a single adder cell.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..64.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous and active-high.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepted start edge.
- b  input  WIDTH  operand B; captured on the accepted start edge.
- cin  input  1  carry-in; captured on the accepted start edge.
- ready  output  1  high in IDLE only.
- busy  output  1  high in RUN only.
- done  output  1  one-cycle pulse in DONE.
- sum  output  WIDTH  result register.
- cout  output  1  final carry-out.
- sub  input  1  subtract select; present only with SERIAL_ADD_SUB_EN.
- ovf  output  1  signed overflow; present only with SERIAL_ADD_SUB_EN.

## Operation
States:
- IDLE: ready=1.
  - start=1: load the A shift register, load the B shift register, load the carry flop with cin, clear the bit counter; go to RUN.
  - start=0: stay in IDLE.
- RUN: busy=1. Each cycle, feed a_sr[0], b_sr[0] and the carry flop to the cell.
  - Shift the cell sum bit into sum[WIDTH-1]; sum shifts right.
  - Shift a_sr and b_sr right.
  - Load the carry flop with the cell carry-out; increment the counter.
  - Counter reaching WIDTH-1 on this edge: go to DONE.
- DONE: done=1, cout = carry flop; unconditionally go to IDLE next edge.

Handshake and result rules:
- start outside IDLE is ignored; no queueing.
- start held high continuously restarts on every IDLE cycle, i.e. one operation per WIDTH+2 cycles.
- sum and cout hold their value from DONE until the next accepted start.
- While RUN, sum shows a partial, shifting value and is not valid.

Reset and boundaries:
- Reset values: state IDLE, ready=1, busy=0, done=0, sum=0, cout=0, carry flop=0, counter=0, shift registers=0.
- rst asserted in any state, including mid-RUN, aborts immediately to the reset values; no done pulse for the aborted operation.
- WIDTH=1: RUN lasts exactly one cycle.
- Arithmetic: sum = (a + b + cin) mod 2^WIDTH; cout = bit WIDTH of the full sum. The counter is clog2(WIDTH) bits (minimum 1) and never wraps in normal use.

## Timing
- Edge 0: start accepted in IDLE.
- Edges 1..WIDTH: bits 0..WIDTH-1 processed.
- After edge WIDTH: state is DONE and done=1. Latency from accept to done is WIDTH cycles.
- After edge WIDTH+1: IDLE again, ready=1.
- All outputs are registered or decoded from state only; no combinational path from inputs to outputs.

## Configuration
Macro SERIAL_ADD_SUB_EN.

Defined:
- Adds the sub input, sampled with start.
- sub=1: B is inverted at load and the carry flop loads 1 (cin ignored), so the block computes A-B.
- sub=1: cout=1 means no borrow.
- ovf is registered in DONE as (a[MSB]==b_eff[MSB]) && (sum[MSB]!=a[MSB]), where b_eff is the B value actually loaded (inverted when sub=1).
- ovf resets to 0 and holds with sum.

Undefined:
- No sub or ovf ports; add-only behaviour as above.

## Structure
- Package serial_add_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - a function computing counter width from WIDTH.
- One sub-module, full_adder_cell: combinational; inputs a, b, cin; outputs s, co. s = a^b^cin; co = majority(a, b, cin).
- The controller instantiates exactly one full_adder_cell.

## Test plan
All scenarios WIDTH=8 unless stated.
- Basic add: a=0x5A, b=0x3C, cin=0, start at edge 0 -> done at edge 8 only; sum=0x96, cout=0; ready back after edge 9.
- Carry ripple: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Ignored start: pulse start with a=0x11, b=0x11 during RUN cycle 3 of the 0x5A+0x3C operation -> result still 0x96; no extra done pulse.
- Reset mid-op: rst at RUN cycle 4 -> sum=0, cout=0, busy=0, done=0, ready=1; next start with a=0x01, b=0x02 -> sum=0x03.
- Continuous start held high with WIDTH=1: a=1, b=1, cin=1 -> sum=1, cout=1; done every 3 cycles.
- SERIAL_ADD_SUB_EN, sub=1: a=0x10, b=0x20 -> sum=0xF0, cout=0, ovf=0; a=0x80, b=0x01 -> sum=0x7F, cout=1, ovf=1.
